// File: rtl/tx_uart_fifo.sv
// UART transmitter with a transmit FIFO and a parametrised frame format.
// Define TX_BREAK_EN to add the send_break input for line-break generation.
module tx_uart_fifo #(
    parameter int WL         = 8,
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              data_vld,
    input  logic [WL-1:0]                     tx_word,
`ifdef TX_BREAK_EN
    input  logic                              send_break,
`endif
    output logic                              data_rdy,
    output logic                              uart_tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int NW  = $clog2(FIFO_DEPTH + 1);
    localparam int BW  = $clog2(WL + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_GAP
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [BW-1:0]   bit_idx, bit_idx_nx;
    logic [WL-1:0]   shift, shift_nx;
    logic            par_bit, par_nx;
    logic            line_nx;
    logic            pop, push, tc, brk;

    logic [WL-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [NW-1:0]   count_nx;
    logic [WL-1:0]   head;

`ifdef TX_BREAK_EN
    assign brk = send_break;
`else
    assign brk = 1'b0;
`endif

    assign push = data_vld && data_rdy;
    assign head = mem[rd_ptr];
    assign tc   = (cnt == '0);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        par_nx     = par_bit;
        line_nx    = 1'b1;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (brk)
                    state_nx = S_BREAK;
                else if (fifo_count != '0)
                    pop = 1'b1;
            end
            S_START: begin
                line_nx = 1'b0;
                if (tc) begin
                    cnt_nx     = CW'(DIV - 1);
                    bit_idx_nx = '0;
                    state_nx   = S_DATA;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_DATA: begin
                line_nx = shift[0];
                if (tc) begin
                    cnt_nx   = CW'(DIV - 1);
                    shift_nx = shift >> 1;
                    if (bit_idx == BW'(WL - 1)) begin
                        bit_idx_nx = '0;
                        state_nx   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_nx = bit_idx + BW'(1);
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_PARITY: begin
                line_nx = par_bit;
                if (tc) begin
                    cnt_nx     = CW'(DIV - 1);
                    bit_idx_nx = '0;
                    state_nx   = S_STOP;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_STOP: begin
                if (tc) begin
                    if (bit_idx != BW'(STOP_BITS - 1)) begin
                        bit_idx_nx = bit_idx + BW'(1);
                        cnt_nx     = CW'(DIV - 1);
                    end else if (brk) begin
                        state_nx = S_BREAK;
                    end else if (fifo_count != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_BREAK: begin
                line_nx = 1'b0;
                if (!brk) begin
                    cnt_nx   = CW'(DIV - 1);
                    state_nx = S_GAP;
                end
            end
            S_GAP: begin
                // one full idle bit after a break before any start bit
                if (tc) begin
                    if (brk)
                        state_nx = S_BREAK;
                    else if (fifo_count != '0)
                        pop = 1'b1;
                    else
                        state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (pop) begin
            shift_nx = head;
            par_nx   = (PARITY == 2) ? ~(^head) : ^head;
            cnt_nx   = CW'(DIV - 1);
            state_nx = S_START;
        end
    end

    always_comb begin
        count_nx = fifo_count;
        if (push && !pop)
            count_nx = fifo_count + NW'(1);
        else if (!push && pop)
            count_nx = fifo_count - NW'(1);
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= tx_word;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            data_rdy   <= 1'b1;
            uart_tx    <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            bit_idx    <= bit_idx_nx;
            shift      <= shift_nx;
            par_bit    <= par_nx;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= count_nx;
            // ready follows the post-edge count so a full FIFO never accepts
            data_rdy   <= (count_nx != NW'(FIFO_DEPTH));
            uart_tx    <= line_nx;
            busy       <= (state != S_IDLE) || (fifo_count != '0);
        end
    end

endmodule

// File: tb/tb_tx_uart_fifo.sv
// Directed bench for tx_uart_fifo: two instances (even/1 stop, odd/2 stops), DIV=16.
module tb_tx_uart_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vld_a, vld_b;
    logic [7:0] word_a, word_b;
    logic       rdy_a, rdy_b, tx_a, tx_b, busy_a, busy_b;
    logic [2:0] cnt_a, cnt_b;
`ifdef TX_BREAK_EN
    logic       brk_a, brk_b;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int peak = 0;
    int rdy_bad = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    tx_uart_fifo #(.WL(8), .CLK_FREQ(1600), .BAUD_RATE(100), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
        .CLK(clk), .RST_N(rst_n), .data_vld(vld_a), .tx_word(word_a),
`ifdef TX_BREAK_EN
        .send_break(brk_a),
`endif
        .data_rdy(rdy_a), .uart_tx(tx_a), .busy(busy_a), .fifo_count(cnt_a));

    tx_uart_fifo #(.WL(8), .CLK_FREQ(1600), .BAUD_RATE(100), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_b (
        .CLK(clk), .RST_N(rst_n), .data_vld(vld_b), .tx_word(word_b),
`ifdef TX_BREAK_EN
        .send_break(brk_b),
`endif
        .data_rdy(rdy_b), .uart_tx(tx_b), .busy(busy_b), .fifo_count(cnt_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic line_of(input int sel);
        return (sel == 1) ? tx_b : tx_a;
    endfunction

    // Called at the negedge inside frame cycle 0; returns at the negedge of the last cycle.
    task automatic frame_check(input int sel, input logic [7:0] w, input logic par,
                               input int nstop, input string tag);
        logic bits [0:11];
        int   nb;
        int   good;
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin
            bits[nb] = w[i]; nb++;
        end
        bits[nb] = par; nb++;
        for (int i = 0; i < nstop; i++) begin
            bits[nb] = 1'b1; nb++;
        end
        for (int b = 0; b < nb; b++) begin
            good = 0;
            for (int c = 0; c < 16; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (line_of(sel) === bits[b]) good++;
            end
            chk($sformatf("%s_bit%0d", tag, b), 32'(good), 32'd16);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(cnt_a) > peak) peak = int'(cnt_a);
            if (rdy_a !== (cnt_a != 3'd4)) rdy_bad++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones;
        rst_n = 1'b0; vld_a = 1'b0; vld_b = 1'b0; word_a = '0; word_b = '0;
`ifdef TX_BREAK_EN
        brk_a = 1'b0; brk_b = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_a), 32'd1);
        chk("rst_rdy", 32'(rdy_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_cnt", 32'(cnt_a), 32'd0);
        chk("rst_tx_b", 32'(tx_b), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // even parity, one stop bit: 0xA5 -> parity 0
        vld_a = 1'b1; word_a = 8'hA5;
        @(negedge clk); vld_a = 1'b0;
        chk("t1_cnt", 32'(cnt_a), 32'd1);
        @(negedge clk);
        chk("t1_lat1", 32'(tx_a), 32'd1);
        @(negedge clk);
        frame_check(0, 8'hA5, 1'b0, 1, "t1");
        chk("t1_busy_last", 32'(busy_a), 32'd1);
        @(negedge clk);
        chk("t1_busy_drop", 32'(busy_a), 32'd0);
        chk("t1_idle", 32'(tx_a), 32'd1);

        // odd parity, two stop bits: 0xA5 -> parity 1, frame 192 cycles
        vld_b = 1'b1; word_b = 8'hA5;
        @(negedge clk); vld_b = 1'b0;
        @(negedge clk);
        chk("t2_lat1", 32'(tx_b), 32'd1);
        @(negedge clk);
        frame_check(1, 8'hA5, 1'b1, 2, "t2");
        chk("t2_busy_last", 32'(busy_b), 32'd1);
        @(negedge clk);
        chk("t2_busy_drop", 32'(busy_b), 32'd0);

        // five words with data_vld held: back-to-back frames
        peak = 0; rdy_bad = 0; mon_en = 1'b1;
        fork
            begin
                int i;
                int guard;
                logic r;
                i = 0; guard = 0;
                while (i < 5 && guard < 400) begin
                    vld_a = 1'b1; word_a = 8'(i + 1);
                    r = rdy_a;
                    @(negedge clk);
                    if (r) i++;
                    guard++;
                end
                vld_a = 1'b0;
                chk("t3_accepted", 32'(i), 32'd5);
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (tx_a !== 1'b0 && n < 20) begin
                    @(negedge clk); n++;
                end
                chk("t3_fall", 32'(tx_a), 32'd0);
                frame_check(0, 8'h01, 1'b1, 1, "t3a");
                @(negedge clk); frame_check(0, 8'h02, 1'b1, 1, "t3b");
                @(negedge clk); frame_check(0, 8'h03, 1'b0, 1, "t3c");
                @(negedge clk); frame_check(0, 8'h04, 1'b1, 1, "t3d");
                @(negedge clk); frame_check(0, 8'h05, 1'b0, 1, "t3e");
                chk("t3_busy_last", 32'(busy_a), 32'd1);
                @(negedge clk);
                chk("t3_busy_drop", 32'(busy_a), 32'd0);
            end
        join
        chk("t3_peak", 32'(peak), 32'd4);
        chk("t3_rdy_track", 32'(rdy_bad), 32'd0);

        // reset in the middle of a frame with one word still queued
        @(negedge clk);
        vld_a = 1'b1; word_a = 8'hFF;
        @(negedge clk); word_a = 8'h11;
        @(negedge clk); vld_a = 1'b0;
        @(negedge clk);
        chk("t4_start", 32'(tx_a), 32'd0);
        repeat (49) @(negedge clk);
        chk("t4_cnt_pre", 32'(cnt_a), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_rst_tx", 32'(tx_a), 32'd1);
        chk("t4_rst_cnt", 32'(cnt_a), 32'd0);
        chk("t4_rst_rdy", 32'(rdy_a), 32'd1);
        chk("t4_rst_busy", 32'(busy_a), 32'd0);
        rst_n = 1'b1;
        ones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_a === 1'b1) ones++;
        end
        chk("t4_quiet", 32'(ones), 32'd40);
        vld_a = 1'b1; word_a = 8'h3C;
        @(negedge clk); vld_a = 1'b0;
        @(negedge clk);
        chk("t4_lat1", 32'(tx_a), 32'd1);
        @(negedge clk);
        frame_check(0, 8'h3C, 1'b0, 1, "t4");
        @(negedge clk);
        chk("t4_busy_drop", 32'(busy_a), 32'd0);

        // push lands on the same edge as the stop-end pop
        vld_a = 1'b1; word_a = 8'h11;
        @(negedge clk); word_a = 8'h22;
        @(negedge clk); word_a = 8'h33;
        @(negedge clk); vld_a = 1'b0;
        chk("t5_start", 32'(tx_a), 32'd0);
        repeat (174) @(negedge clk);
        chk("t5_cnt_pre", 32'(cnt_a), 32'd2);
        vld_a = 1'b1; word_a = 8'h44;
        @(negedge clk); vld_a = 1'b0;
        chk("t5_cnt_same", 32'(cnt_a), 32'd2);
        chk("t5_stop", 32'(tx_a), 32'd1);
        @(negedge clk); frame_check(0, 8'h22, 1'b0, 1, "t5a");
        @(negedge clk); frame_check(0, 8'h33, 1'b0, 1, "t5b");
        @(negedge clk); frame_check(0, 8'h44, 1'b0, 1, "t5c");
        @(negedge clk);
        chk("t5_busy_drop", 32'(busy_a), 32'd0);

`ifdef TX_BREAK_EN
        // 100-cycle break while idle, a word queued during it
        begin
            int zeros;
            @(negedge clk);
            brk_a = 1'b1;
            @(negedge clk);
            vld_a = 1'b1; word_a = 8'h5A;
            zeros = 0;
            for (int i = 1; i <= 100; i++) begin
                @(negedge clk);
                if (i == 1) vld_a = 1'b0;
                if (tx_a === 1'b0) zeros++;
                if (i == 50) chk("t6_cnt_hold", 32'(cnt_a), 32'd1);
                if (i == 99) brk_a = 1'b0;
            end
            chk("t6_break_len", 32'(zeros), 32'd100);
            ones = 0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (tx_a === 1'b1) ones++;
            end
            chk("t6_gap_len", 32'(ones), 32'd16);
            @(negedge clk);
            frame_check(0, 8'h5A, 1'b0, 1, "t6");
            @(negedge clk);
            chk("t6_busy_drop", 32'(busy_a), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
